// File: rtl/pulse_width_meter_if.sv
// ============================================================================
// Module   : pulse_width_meter_if
// Purpose  : Pulse input and measurement results of pulse_width_meter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pulse_width_meter_if #(
  parameter int WIDTH = 8
) ();
  logic             signal;
  logic [WIDTH-1:0] high_width;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] pulse_count;
  logic             valid;
  logic             overflow;

  // master drives the pulse train and reads results; slave is the meter
  modport master (
    output signal,
    input  high_width,
    input  period,
    input  pulse_count,
    input  valid,
    input  overflow
  );

  modport slave (
    input  signal,
    output high_width,
    output period,
    output pulse_count,
    output valid,
    output overflow
  );
endinterface

`default_nettype wire

// File: rtl/pulse_width_meter.sv
// ============================================================================
// Module   : pulse_width_meter
// Purpose  : Measures high width and period of an asynchronous pulse train.
//            Optional macro PULSE_METER_GLITCH_FILTER_EN drops 1-cycle glitches.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pulse_width_meter #(
  parameter int WIDTH = 8
) (
  input  wire logic           clock,
  input  wire logic           reset_n,
  pulse_width_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_meta;
  logic             r_sync;
  logic             r_prev;
  logic             w_level;
  logic             w_rise;
  logic             w_fall;

  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_pcnt;
  logic [WIDTH-1:0] r_high_width;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_pulse_count;
  logic             r_valid;
  logic             r_overflow;

  logic [WIDTH-1:0] w_hcnt_nxt;
  logic [WIDTH-1:0] w_pcnt_nxt;
  logic [WIDTH-1:0] w_high_width_nxt;
  logic [WIDTH-1:0] w_period_nxt;
  logic [WIDTH-1:0] w_pulse_count_nxt;
  logic             w_valid_nxt;
  logic             w_overflow_nxt;

  logic             w_hsat;
  logic             w_psat;
  logic [WIDTH-1:0] w_hcnt_inc;
  logic [WIDTH-1:0] w_pcnt_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= bus.signal;
      r_sync <= r_meta;
    end
  end

`ifdef PULSE_METER_GLITCH_FILTER_EN
  logic r_filt;

  // r_meta is the next r_sync sample, so equality means two consecutive equal sync samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= 1'b0;
    end else if (r_meta == r_sync) begin
      r_filt <= r_sync;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;

  // counters stick at full scale so a latched measurement reads all-ones
  assign w_hsat     = (r_hcnt == C_MAX);
  assign w_psat     = (r_pcnt == C_MAX);
  assign w_hcnt_inc = w_hsat ? C_MAX : (r_hcnt + C_ONE);
  assign w_pcnt_inc = w_psat ? C_MAX : (r_pcnt + C_ONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_hcnt        <= '0;
      r_pcnt        <= '0;
      r_high_width  <= '0;
      r_period      <= '0;
      r_pulse_count <= '0;
      r_valid       <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hcnt        <= w_hcnt_nxt;
      r_pcnt        <= w_pcnt_nxt;
      r_high_width  <= w_high_width_nxt;
      r_period      <= w_period_nxt;
      r_pulse_count <= w_pulse_count_nxt;
      r_valid       <= w_valid_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_hcnt_nxt        = r_hcnt;
    w_pcnt_nxt        = r_pcnt;
    w_high_width_nxt  = r_high_width;
    w_period_nxt      = r_period;
    w_pulse_count_nxt = r_pulse_count;
    w_valid_nxt       = 1'b0;
    w_overflow_nxt    = r_overflow;

    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt       = S_HIGH;
          w_hcnt_nxt        = C_ONE;
          w_pcnt_nxt        = C_ONE;
          w_pulse_count_nxt = r_pulse_count + C_ONE;
        end
      end

      S_HIGH: begin
        w_pcnt_nxt = w_pcnt_inc;
        if (w_psat) begin
          w_overflow_nxt = 1'b1;
        end
        if (w_fall) begin
          w_state_nxt      = S_LOW;
          w_high_width_nxt = r_hcnt;
        end else begin
          w_hcnt_nxt = w_hcnt_inc;
          if (w_hsat) begin
            w_overflow_nxt = 1'b1;
          end
        end
      end

      S_LOW: begin
        if (w_rise) begin
          w_state_nxt       = S_HIGH;
          w_period_nxt      = r_pcnt;
          w_valid_nxt       = 1'b1;
          w_pulse_count_nxt = r_pulse_count + C_ONE;
          w_hcnt_nxt        = C_ONE;
          w_pcnt_nxt        = C_ONE;
        end else begin
          w_pcnt_nxt = w_pcnt_inc;
          if (w_psat) begin
            w_overflow_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.high_width  = r_high_width;
  assign bus.period      = r_period;
  assign bus.pulse_count = r_pulse_count;
  assign bus.valid       = r_valid;
  assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire
